// File: rtl/alu_rs_if.sv
// Dispatch, result-broadcast and issue signals of the ALU reservation station.
// The dispatcher/bench side uses the master modport, alu_rs uses slave.
interface alu_rs_if #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4,
  parameter int OP_W   = 6
);
  logic              enDisp;
  logic [OP_W-1:0]   dispOp;
  logic [TAG_W-1:0]  dispDestTag;
  logic [DATA_W-1:0] dispDataO;
  logic [DATA_W-1:0] dispDataT;
  logic [TAG_W-1:0]  dispTagO;
  logic [TAG_W-1:0]  dispTagT;

  logic              ALUwrtEn;
  logic [TAG_W-1:0]  ALUwrtTag;
  logic [DATA_W-1:0] ALUwrtData;
  logic              LSwrtEn;
  logic [TAG_W-1:0]  LSwrtTag;
  logic [DATA_W-1:0] LSwrtData;

  logic              aluReady;

  logic              issEn;
  logic [OP_W-1:0]   issOp;
  logic [DATA_W-1:0] issDataO;
  logic [DATA_W-1:0] issDataT;
  logic [TAG_W-1:0]  issDestTag;
  logic              rsFull;

  modport master (
    output enDisp, dispOp, dispDestTag, dispDataO, dispDataT, dispTagO, dispTagT,
    output ALUwrtEn, ALUwrtTag, ALUwrtData, LSwrtEn, LSwrtTag, LSwrtData,
    output aluReady,
    input  issEn, issOp, issDataO, issDataT, issDestTag, rsFull
  );

  modport slave (
    input  enDisp, dispOp, dispDestTag, dispDataO, dispDataT, dispTagO, dispTagT,
    input  ALUwrtEn, ALUwrtTag, ALUwrtData, LSwrtEn, LSwrtTag, LSwrtData,
    input  aluReady,
    output issEn, issOp, issDataO, issDataT, issDestTag, rsFull
  );
endinterface

// File: rtl/alu_rs.sv
// ALU reservation station: tag-snooping operand wakeup, single registered issue.
// Define RS_OLDEST_FIRST_EN to select the oldest ready slot instead of the lowest index.
module alu_rs #(
  parameter int DATA_W  = 32,
  parameter int TAG_W   = 4,
  parameter int OP_W    = 6,
  parameter int ENTRIES = 8
) (
  input logic     clk,
  input logic     rst,
  alu_rs_if.slave rs
);
  localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
  localparam int CNT_W = $clog2(ENTRIES + 1);

  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [CNT_W-1:0] cnt_t;
  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } opnd_t;

  logic [ENTRIES-1:0] busy_q, busy_d;
  logic [OP_W-1:0]    op_q     [ENTRIES];
  logic [OP_W-1:0]    op_d     [ENTRIES];
  logic [TAG_W-1:0]   dest_q   [ENTRIES];
  logic [TAG_W-1:0]   dest_d   [ENTRIES];
  logic [TAG_W-1:0]   tag_o_q  [ENTRIES];
  logic [TAG_W-1:0]   tag_o_d  [ENTRIES];
  logic [TAG_W-1:0]   tag_t_q  [ENTRIES];
  logic [TAG_W-1:0]   tag_t_d  [ENTRIES];
  logic [DATA_W-1:0]  data_o_q [ENTRIES];
  logic [DATA_W-1:0]  data_o_d [ENTRIES];
  logic [DATA_W-1:0]  data_t_q [ENTRIES];
  logic [DATA_W-1:0]  data_t_d [ENTRIES];
`ifdef RS_OLDEST_FIRST_EN
  // age = number of older busy slots, so age 0 is the oldest entry
  idx_t               age_q    [ENTRIES];
  idx_t               age_d    [ENTRIES];
  idx_t               sel_age;
`endif

  logic               iss_en_q, iss_en_d;
  logic [OP_W-1:0]    iss_op_q, iss_op_d;
  logic [DATA_W-1:0]  iss_data_o_q, iss_data_o_d;
  logic [DATA_W-1:0]  iss_data_t_q, iss_data_t_d;
  logic [TAG_W-1:0]   iss_dest_q, iss_dest_d;
  logic               full_q, full_d;

  logic [ENTRIES-1:0] issuable;
  logic               sel_vld, free_vld, do_issue, do_disp;
  logic               alu_vld, ls_vld;
  idx_t               sel_idx, free_idx;
  cnt_t               busy_cnt_q, busy_cnt_d;

  function automatic cnt_t popcount(input logic [ENTRIES-1:0] v);
    cnt_t c;
    c = '0;
    for (int i = 0; i < ENTRIES; i++) c = c + cnt_t'(v[i]);
    return c;
  endfunction

  function automatic opnd_t snoop(
    input logic [TAG_W-1:0]  tag,
    input logic [DATA_W-1:0] data,
    input logic              a_vld,
    input logic [TAG_W-1:0]  a_tag,
    input logic [DATA_W-1:0] a_data,
    input logic              l_vld,
    input logic [TAG_W-1:0]  l_tag,
    input logic [DATA_W-1:0] l_data
  );
    opnd_t r;
    r.tag  = tag;
    r.data = data;
    if (tag != '0) begin
      if (a_vld && (a_tag == tag)) begin
        r.tag  = '0;
        r.data = a_data;
      end else if (l_vld && (l_tag == tag)) begin
        r.tag  = '0;
        r.data = l_data;
      end
    end
    return r;
  endfunction

  assign alu_vld    = rs.ALUwrtEn && (rs.ALUwrtTag != '0);
  assign ls_vld     = rs.LSwrtEn && (rs.LSwrtTag != '0);
  assign busy_cnt_q = popcount(busy_q);

  always_comb begin
    issuable = '0;
    for (int i = 0; i < ENTRIES; i++)
      issuable[i] = busy_q[i] && (tag_o_q[i] == '0) && (tag_t_q[i] == '0);

    sel_vld = 1'b0;
    sel_idx = '0;
`ifdef RS_OLDEST_FIRST_EN
    sel_age = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (issuable[i] && (!sel_vld || (age_q[i] < sel_age))) begin
        sel_vld = 1'b1;
        sel_idx = idx_t'(i);
        sel_age = age_q[i];
      end
    end
`else
    for (int i = 0; i < ENTRIES; i++) begin
      if (issuable[i] && !sel_vld) begin
        sel_vld = 1'b1;
        sel_idx = idx_t'(i);
      end
    end
`endif
    do_issue = sel_vld && rs.aluReady;

    // free slot is chosen from pre-edge occupancy, so a slot issuing now is not reused this edge
    free_vld = 1'b0;
    free_idx = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (!busy_q[i] && !free_vld) begin
        free_vld = 1'b1;
        free_idx = idx_t'(i);
      end
    end
    do_disp = rs.enDisp && !full_q && free_vld;

    busy_d = busy_q;
    for (int i = 0; i < ENTRIES; i++) begin
      op_d[i]     = op_q[i];
      dest_d[i]   = dest_q[i];
      tag_o_d[i]  = tag_o_q[i];
      data_o_d[i] = data_o_q[i];
      tag_t_d[i]  = tag_t_q[i];
      data_t_d[i] = data_t_q[i];
      if (busy_q[i]) begin
        {tag_o_d[i], data_o_d[i]} = snoop(tag_o_q[i], data_o_q[i],
                                          alu_vld, rs.ALUwrtTag, rs.ALUwrtData,
                                          ls_vld, rs.LSwrtTag, rs.LSwrtData);
        {tag_t_d[i], data_t_d[i]} = snoop(tag_t_q[i], data_t_q[i],
                                          alu_vld, rs.ALUwrtTag, rs.ALUwrtData,
                                          ls_vld, rs.LSwrtTag, rs.LSwrtData);
      end
`ifdef RS_OLDEST_FIRST_EN
      age_d[i] = age_q[i];
      if (do_issue && busy_q[i] && (age_q[i] > sel_age))
        age_d[i] = age_q[i] - idx_t'(1);
`endif
    end

    if (do_issue) busy_d[sel_idx] = 1'b0;

    if (do_disp) begin
      busy_d[free_idx] = 1'b1;
      op_d[free_idx]   = rs.dispOp;
      dest_d[free_idx] = rs.dispDestTag;
      {tag_o_d[free_idx], data_o_d[free_idx]} = snoop(rs.dispTagO, rs.dispDataO,
                                                      alu_vld, rs.ALUwrtTag, rs.ALUwrtData,
                                                      ls_vld, rs.LSwrtTag, rs.LSwrtData);
      {tag_t_d[free_idx], data_t_d[free_idx]} = snoop(rs.dispTagT, rs.dispDataT,
                                                      alu_vld, rs.ALUwrtTag, rs.ALUwrtData,
                                                      ls_vld, rs.LSwrtTag, rs.LSwrtData);
`ifdef RS_OLDEST_FIRST_EN
      age_d[free_idx] = idx_t'(busy_cnt_q - cnt_t'(do_issue));
`endif
    end

    busy_cnt_d = popcount(busy_d);
    full_d     = (busy_cnt_d == cnt_t'(ENTRIES));

    iss_en_d     = do_issue;
    iss_op_d     = iss_op_q;
    iss_data_o_d = iss_data_o_q;
    iss_data_t_d = iss_data_t_q;
    iss_dest_d   = iss_dest_q;
    if (do_issue) begin
      iss_op_d     = op_q[sel_idx];
      iss_data_o_d = data_o_q[sel_idx];
      iss_data_t_d = data_t_q[sel_idx];
      iss_dest_d   = dest_q[sel_idx];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q       <= '0;
      iss_en_q     <= 1'b0;
      iss_op_q     <= '0;
      iss_data_o_q <= '0;
      iss_data_t_q <= '0;
      iss_dest_q   <= '0;
      full_q       <= 1'b0;
      for (int i = 0; i < ENTRIES; i++) begin
        op_q[i]     <= '0;
        dest_q[i]   <= '0;
        tag_o_q[i]  <= '0;
        data_o_q[i] <= '0;
        tag_t_q[i]  <= '0;
        data_t_q[i] <= '0;
`ifdef RS_OLDEST_FIRST_EN
        age_q[i]    <= '0;
`endif
      end
    end else begin
      busy_q       <= busy_d;
      iss_en_q     <= iss_en_d;
      iss_op_q     <= iss_op_d;
      iss_data_o_q <= iss_data_o_d;
      iss_data_t_q <= iss_data_t_d;
      iss_dest_q   <= iss_dest_d;
      full_q       <= full_d;
      for (int i = 0; i < ENTRIES; i++) begin
        op_q[i]     <= op_d[i];
        dest_q[i]   <= dest_d[i];
        tag_o_q[i]  <= tag_o_d[i];
        data_o_q[i] <= data_o_d[i];
        tag_t_q[i]  <= tag_t_d[i];
        data_t_q[i] <= data_t_d[i];
`ifdef RS_OLDEST_FIRST_EN
        age_q[i]    <= age_d[i];
`endif
      end
    end
  end

  assign rs.issEn      = iss_en_q;
  assign rs.issOp      = iss_op_q;
  assign rs.issDataO   = iss_data_o_q;
  assign rs.issDataT   = iss_data_t_q;
  assign rs.issDestTag = iss_dest_q;
  assign rs.rsFull     = full_q;
endmodule

// File: tb/tb_alu_rs.sv
// Self-checking bench for alu_rs: directed scenarios plus random traffic against a slot/queue model.
module tb_alu_rs;
  localparam int ENT = 8;

  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_err = 0;

  alu_rs_if #(.DATA_W(32), .TAG_W(4), .OP_W(6)) rs_if ();

  alu_rs #(.DATA_W(32), .TAG_W(4), .OP_W(6), .ENTRIES(ENT)) dut (
    .clk (clk),
    .rst (rst),
    .rs  (rs_if)
  );

  always #5 clk = ~clk;

  // reference state: one record per slot plus dispatch-order queue of busy slots
  bit          m_busy [ENT];
  logic [5:0]  m_op   [ENT];
  logic [3:0]  m_dest [ENT];
  logic [3:0]  m_to   [ENT];
  logic [3:0]  m_tt   [ENT];
  logic [31:0] m_do   [ENT];
  logic [31:0] m_dt   [ENT];
  int          m_order[$];
  logic        e_en, e_full;
  logic [5:0]  e_op;
  logic [31:0] e_do, e_dt;
  logic [3:0]  e_dest;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < ENT; i++) begin
      m_busy[i] = 0; m_op[i] = '0; m_dest[i] = '0;
      m_to[i] = '0; m_tt[i] = '0; m_do[i] = '0; m_dt[i] = '0;
    end
    m_order.delete();
    e_en = 0; e_full = 0; e_op = '0; e_do = '0; e_dt = '0; e_dest = '0;
  endtask

  function automatic void wake(inout logic [3:0] t, inout logic [31:0] d);
    if (t != '0) begin
      if (rs_if.ALUwrtEn && rs_if.ALUwrtTag == t) begin
        d = rs_if.ALUwrtData; t = '0;
      end else if (rs_if.LSwrtEn && rs_if.LSwrtTag == t) begin
        d = rs_if.LSwrtData; t = '0;
      end
    end
  endfunction

  task automatic model_eval();
    int sel = -1;
    int fr = -1;
    int cnt = 0;
    logic [3:0]  t;
    logic [31:0] d;
`ifdef RS_OLDEST_FIRST_EN
    foreach (m_order[k])
      if (sel < 0 && m_to[m_order[k]] == '0 && m_tt[m_order[k]] == '0) sel = m_order[k];
`else
    for (int i = 0; i < ENT; i++)
      if (sel < 0 && m_busy[i] && m_to[i] == '0 && m_tt[i] == '0) sel = i;
`endif
    if (rs_if.enDisp && !e_full)
      for (int i = 0; i < ENT; i++) if (fr < 0 && !m_busy[i]) fr = i;
    for (int i = 0; i < ENT; i++)
      if (m_busy[i]) begin
        wake(m_to[i], m_do[i]);
        wake(m_tt[i], m_dt[i]);
      end
    e_en = 0;
    if (rs_if.aluReady && sel >= 0) begin
      int pos = -1;
      e_en = 1; e_op = m_op[sel]; e_do = m_do[sel]; e_dt = m_dt[sel]; e_dest = m_dest[sel];
      m_busy[sel] = 0;
      foreach (m_order[k]) if (m_order[k] == sel) pos = k;
      if (pos >= 0) m_order.delete(pos);
    end
    if (fr >= 0) begin
      m_busy[fr] = 1; m_op[fr] = rs_if.dispOp; m_dest[fr] = rs_if.dispDestTag;
      t = rs_if.dispTagO; d = rs_if.dispDataO; wake(t, d); m_to[fr] = t; m_do[fr] = d;
      t = rs_if.dispTagT; d = rs_if.dispDataT; wake(t, d); m_tt[fr] = t; m_dt[fr] = d;
      m_order.push_back(fr);
    end
    for (int i = 0; i < ENT; i++) if (m_busy[i]) cnt++;
    e_full = (cnt == ENT);
  endtask

  task automatic tick();
    model_eval();
    @(posedge clk);
    #1;
    chk("issEn", 64'(rs_if.issEn), 64'(e_en));
    chk("rsFull", 64'(rs_if.rsFull), 64'(e_full));
    chk("issOp", 64'(rs_if.issOp), 64'(e_op));
    chk("issDataO", 64'(rs_if.issDataO), 64'(e_do));
    chk("issDataT", 64'(rs_if.issDataT), 64'(e_dt));
    chk("issDestTag", 64'(rs_if.issDestTag), 64'(e_dest));
  endtask

  task automatic idle();
    rs_if.enDisp = 0; rs_if.dispOp = '0; rs_if.dispDestTag = 4'd1;
    rs_if.dispDataO = '0; rs_if.dispDataT = '0; rs_if.dispTagO = '0; rs_if.dispTagT = '0;
    rs_if.ALUwrtEn = 0; rs_if.ALUwrtTag = '0; rs_if.ALUwrtData = '0;
    rs_if.LSwrtEn = 0; rs_if.LSwrtTag = '0; rs_if.LSwrtData = '0;
    rs_if.aluReady = 0;
  endtask

  task automatic disp(input logic [5:0] op, input logic [3:0] dest,
                      input logic [3:0] to, input logic [31:0] dop,
                      input logic [3:0] tt, input logic [31:0] dt);
    rs_if.enDisp = 1; rs_if.dispOp = op; rs_if.dispDestTag = dest;
    rs_if.dispTagO = to; rs_if.dispDataO = dop; rs_if.dispTagT = tt; rs_if.dispDataT = dt;
  endtask

  task automatic reset_check(input string tag);
    chk({tag, "_issEn"}, 64'(rs_if.issEn), 64'(0));
    chk({tag, "_rsFull"}, 64'(rs_if.rsFull), 64'(0));
    chk({tag, "_issOp"}, 64'(rs_if.issOp), 64'(0));
    chk({tag, "_issDataO"}, 64'(rs_if.issDataO), 64'(0));
    chk({tag, "_issDataT"}, 64'(rs_if.issDataT), 64'(0));
    chk({tag, "_issDest"}, 64'(rs_if.issDestTag), 64'(0));
  endtask

  // asserts reset a few ns after a rising edge, well clear of any clock edge
  task automatic mid_reset(input string tag);
    idle();
    #3 rst = 0;
    #1;
    model_reset();
    reset_check(tag);
    #2 rst = 1;
  endtask

  task automatic random_phase(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      rs_if.enDisp      = ($urandom_range(0, 9) < 6);
      rs_if.dispOp      = 6'($urandom);
      rs_if.dispDestTag = 4'($urandom_range(1, 15));
      rs_if.dispTagO    = $urandom_range(0, 1) ? 4'($urandom_range(1, 15)) : 4'd0;
      rs_if.dispTagT    = $urandom_range(0, 1) ? 4'($urandom_range(1, 15)) : 4'd0;
      rs_if.dispDataO   = $urandom;
      rs_if.dispDataT   = $urandom;
      rs_if.ALUwrtEn    = 1'($urandom_range(0, 1));
      rs_if.ALUwrtTag   = 4'($urandom_range(0, 15));
      rs_if.ALUwrtData  = $urandom;
      rs_if.LSwrtEn     = 1'($urandom_range(0, 1));
      rs_if.LSwrtTag    = 4'($urandom_range(0, 15));
      rs_if.LSwrtData   = $urandom;
      rs_if.aluReady    = ((c / 150) % 2 == 1) ? ($urandom_range(0, 9) < 2)
                                               : ($urandom_range(0, 9) < 7);
      tick();
    end
  endtask

  initial begin
    logic [3:0] first_dest, second_dest;
    idle();
    model_reset();
    rst = 1;
    #2 rst = 0;
    #1 reset_check("por");
    #4 rst = 1;

    // single ready instruction issues one cycle after dispatch
    disp(6'd3, 4'd1, 4'd0, 32'd5, 4'd0, 32'd7);
    rs_if.aluReady = 1;
    tick();
    chk("r031_no_early_issue", 64'(rs_if.issEn), 64'(0));
    idle(); rs_if.aluReady = 1;
    tick();
    chk("r031_issEn", 64'(rs_if.issEn), 64'(1));
    chk("r031_issOp", 64'(rs_if.issOp), 64'(3));
    chk("r031_dataO", 64'(rs_if.issDataO), 64'(5));
    chk("r031_dataT", 64'(rs_if.issDataT), 64'(7));
    chk("r031_rsFull", 64'(rs_if.rsFull), 64'(0));

    // operand waits on tag 4, woken by an ALU broadcast two cycles later
    idle(); rs_if.aluReady = 1;
    disp(6'd1, 4'd2, 4'd4, 32'hdead, 4'd0, 32'd9);
    tick();
    idle(); rs_if.aluReady = 1;
    tick();
    chk("r032_wait", 64'(rs_if.issEn), 64'(0));
    rs_if.ALUwrtEn = 1; rs_if.ALUwrtTag = 4'd4; rs_if.ALUwrtData = 32'h1234;
    tick();
    chk("r032_wake_edge", 64'(rs_if.issEn), 64'(0));
    idle(); rs_if.aluReady = 1;
    tick();
    chk("r032_issEn", 64'(rs_if.issEn), 64'(1));
    chk("r032_dataO", 64'(rs_if.issDataO), 64'h1234);

    // load/store broadcast captured in the dispatch cycle itself
    idle(); rs_if.aluReady = 1;
    disp(6'd2, 4'd3, 4'd0, 32'd1, 4'd6, 32'hbeef);
    rs_if.LSwrtEn = 1; rs_if.LSwrtTag = 4'd6; rs_if.LSwrtData = 32'hAA;
    tick();
    idle(); rs_if.aluReady = 1;
    tick();
    chk("r033_issEn", 64'(rs_if.issEn), 64'(1));
    chk("r033_dataT", 64'(rs_if.issDataT), 64'hAA);

    // fill all slots with the ALU stalled, then drain
    idle();
    for (int i = 0; i < ENT; i++) begin
      disp(6'(i + 8), 4'(i + 1), 4'd0, 32'(i), 4'd0, 32'(i * 3));
      tick();
    end
    chk("r034_full", 64'(rs_if.rsFull), 64'(1));
    disp(6'd63, 4'd15, 4'd0, 32'd99, 4'd0, 32'd99);
    tick();
    chk("r034_ignored_full", 64'(rs_if.rsFull), 64'(1));
    idle(); rs_if.aluReady = 1;
    for (int k = 0; k < ENT; k++) begin
      tick();
      chk("r034_drain_en", 64'(rs_if.issEn), 64'(1));
      chk("r034_drain_dest", 64'(rs_if.issDestTag), 64'(k + 1));
      if (k == 0) chk("r034_full_drop", 64'(rs_if.rsFull), 64'(0));
    end
    tick();
    chk("r034_ninth_dropped", 64'(rs_if.issEn), 64'(0));

    // slot 0 re-dispatched after slot 3; both woken in the same cycle
    idle();
    disp(6'd1, 4'd1, 4'd0, 32'd1, 4'd0, 32'd1);   tick();
    disp(6'd2, 4'd2, 4'd14, 32'd0, 4'd0, 32'd2);  tick();
    disp(6'd3, 4'd3, 4'd14, 32'd0, 4'd0, 32'd3);  tick();
    disp(6'd4, 4'd4, 4'd5, 32'd0, 4'd0, 32'd4);   tick();
    idle(); rs_if.aluReady = 1;
    tick();
    chk("r035_slot0_out", 64'(rs_if.issDestTag), 64'(1));
    idle();
    disp(6'd10, 4'd10, 4'd0, 32'd10, 4'd5, 32'd0); tick();
    idle(); rs_if.ALUwrtEn = 1; rs_if.ALUwrtTag = 4'd5; rs_if.ALUwrtData = 32'h55;
    tick();
    idle(); rs_if.aluReady = 1;
`ifdef RS_OLDEST_FIRST_EN
    first_dest = 4'd4; second_dest = 4'd10;
`else
    first_dest = 4'd10; second_dest = 4'd4;
`endif
    tick();
    chk("r035_first", 64'(rs_if.issDestTag), 64'(first_dest));
    tick();
    chk("r035_second", 64'(rs_if.issDestTag), 64'(second_dest));
    rs_if.ALUwrtEn = 1; rs_if.ALUwrtTag = 4'd14; rs_if.ALUwrtData = 32'h14;
    tick();
    idle(); rs_if.aluReady = 1;
    tick();
    tick();

    // reset while several slots are busy and an issue is on the outputs
    idle();
    for (int i = 0; i < 6; i++) begin
      disp(6'(i), 4'(i + 1), 4'd0, 32'(i + 100), 4'd0, 32'(i + 200));
      tick();
    end
    idle(); rs_if.aluReady = 1;
    tick();
    chk("r036_pre_issEn", 64'(rs_if.issEn), 64'(1));
    mid_reset("r036");
    idle(); rs_if.aluReady = 1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("r036_no_issue", 64'(rs_if.issEn), 64'(0));
    end
    disp(6'd7, 4'd9, 4'd0, 32'h77, 4'd0, 32'h88);
    tick();
    idle(); rs_if.aluReady = 1;
    tick();
    chk("r036_fresh_issue", 64'(rs_if.issDestTag), 64'(9));

    random_phase(1500);
    mid_reset("rand_rst");
    random_phase(1500);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
